// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the fast-monitoring spy-buffer readout.
// Imported by the arbiter and its round-robin picker.
package fm_sb_pkg;

  localparam int FM_N_SB   = 27;
  localparam int FM_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } fm_arb_state_t;

endpackage

// File: rtl/fm_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after
// last_ptr, with wrap-around, via a double-width masked priority encode.
module fm_rr_pick
  import fm_sb_pkg::*;
#(
  parameter int N_REQ = FM_N_SB,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic               hit;

  // Lower copy masked at and below last_ptr; upper copy supplies the wrap.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N_REQ; i++) begin
      if (i <= int'(last_ptr)) dbl[i] = 1'b0;
    end
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < 2*N_REQ; i++) begin
      if (dbl[i] && !hit) begin
        hit = 1'b1;
        idx = (i >= N_REQ) ? SEL_W'(i - N_REQ) : SEL_W'(i);
      end
    end
    onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      onehot[j] = hit && (idx == SEL_W'(j));
    end
  end

  assign any = |req;

endmodule

// File: rtl/fm_sb_rd_arbiter.sv
// Round-robin burst readout arbiter sharing one valid/ready stream
// between the spy buffers, with a per-burst stall timeout.
module fm_sb_rd_arbiter
  import fm_sb_pkg::*;
#(
  parameter int N_REQ   = FM_N_SB,
  parameter int DATA_W  = FM_DATA_W,
  parameter int BURST_W = 8,
  parameter int TMO_W   = 10,
  parameter int SEL_W   = $clog2(N_REQ)
) (
  input  logic                    clk_hs,
  input  logic                    rst_hs,
  input  logic                    enable,
  input  logic [BURST_W-1:0]      burst_len,
  input  logic [TMO_W-1:0]        tmo_limit,
  input  logic                    err_clr,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        src_valid,
  input  logic [N_REQ*DATA_W-1:0] src_data,
  output logic [N_REQ-1:0]        src_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    tmo_err,
  output logic [SEL_W-1:0]        tmo_sel
);

  fm_arb_state_t      state;
  logic [SEL_W-1:0]   last_ptr;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] wcnt;
  logic [TMO_W-1:0]   tcnt;

  logic [N_REQ-1:0]   pick_oh;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  logic               vld;
  logic [DATA_W-1:0]  dat;
  logic               xfer;
  logic               last_w;
  logic [TMO_W:0]     tcnt_nx;
  logic               stall_hit;
  logic               abort;

  fm_rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // AND-OR mux from the registered one-hot grant; zero when idle.
  always_comb begin
    vld = 1'b0;
    dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        vld = vld | src_valid[i];
        dat = dat | src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = vld;
  assign out_data  = dat;
  assign src_ready = grant & {N_REQ{out_ready}};
  assign xfer      = vld & out_ready;
  assign last_w    = (wcnt == len_q - BURST_W'(1));
  assign out_last  = vld & last_w;
  assign busy      = (state == ARB_XFER);

  assign tcnt_nx   = {1'b0, tcnt} + (TMO_W+1)'(1);
  assign stall_hit = (tmo_limit != '0) &&
                     (tcnt_nx >= {1'b0, tmo_limit});
  assign abort     = busy & ~xfer & stall_hit;

  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      out_sel  <= '0;
      last_ptr <= SEL_W'(N_REQ - 1);
      len_q    <= '0;
      wcnt     <= '0;
      tcnt     <= '0;
      tmo_err  <= 1'b0;
      tmo_sel  <= '0;
    end else begin
      if (err_clr) begin
        tmo_err <= 1'b0;
        tmo_sel <= '0;
      end else if (abort && !tmo_err) begin
        tmo_err <= 1'b1;
        tmo_sel <= out_sel;
      end
      case (state)
        ARB_IDLE: begin
          if (enable && pick_any) begin
            state    <= ARB_XFER;
            grant    <= pick_oh;
            out_sel  <= pick_idx;
            last_ptr <= pick_idx;
            len_q    <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            wcnt     <= '0;
            tcnt     <= '0;
          end
        end
        ARB_XFER: begin
          if (xfer) begin
            wcnt <= wcnt + BURST_W'(1);
            tcnt <= '0;
            if (last_w) begin
              state <= ARB_IDLE;
              grant <= '0;
            end
          end else if (tmo_limit != '0) begin
            tcnt <= (&tcnt) ? tcnt : tcnt_nx[TMO_W-1:0];
            if (stall_hit) begin
              state <= ARB_IDLE;
              grant <= '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_sb_rd_arbiter.sv
// Bench for fm_sb_rd_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_fm_sb_rd_arbiter;
  import fm_sb_pkg::*;

  localparam int N  = 27;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int TW = 10;
  localparam int SW = $clog2(N);

  logic            clk_hs = 1'b0;
  logic            rst_hs = 1'b0;
  logic            enable = 1'b0;
  logic [BW-1:0]   burst_len = '0;
  logic [TW-1:0]   tmo_limit = '0;
  logic            err_clr = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            tmo_err;
  logic [SW-1:0]   tmo_sel;

  fm_sb_rd_arbiter #(
    .N_REQ (N), .DATA_W (DW), .BURST_W (BW), .TMO_W (TW), .SEL_W (SW)
  ) dut (
    .clk_hs    (clk_hs),
    .rst_hs    (rst_hs),
    .enable    (enable),
    .burst_len (burst_len),
    .tmo_limit (tmo_limit),
    .err_clr   (err_clr),
    .req       (req),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .tmo_err   (tmo_err),
    .tmo_sel   (tmo_sel)
  );

  always #5 clk_hs = ~clk_hs;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the stream and how many words remain.
  bit m_busy;
  int m_src, m_sel, m_last, m_left, m_stall;
  bit m_err;
  int m_esel;
  int cyc = 0;
  int dut_xfers = 0;
  int dut_lasts = 0;
  int win_q[$];
  int win_cyc[$];

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_sel = 0; m_last = N - 1;
    m_left = 0; m_stall = 0; m_err = 0; m_esel = 0;
  endtask

  function automatic int rr_next();
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all();
    logic [N-1:0] eg;
    bit ev;
    eg = '0;
    if (m_busy) eg[m_src] = 1'b1;
    ev = m_busy && src_valid[m_src];
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("src_ready", 64'(src_ready), 64'(out_ready ? eg : '0));
    chk("out_last", 64'(out_last), 64'(ev && m_left == 1));
    chk("out_sel", 64'(out_sel), 64'(m_sel));
    if (ev) chk("out_data", 64'(out_data), 64'(src_data[m_src*DW +: DW]));
    chk("tmo_err", 64'(tmo_err), 64'(m_err));
    chk("tmo_sel", 64'(tmo_sel), 64'(m_esel));
    if (out_valid && out_ready) dut_xfers++;
    if (out_valid && out_ready && out_last) dut_lasts++;
  endtask

  task automatic model_step();
    bit abort;
    abort = 0;
    if (m_busy) begin
      if (src_valid[m_src] && out_ready) begin
        m_left--;
        m_stall = 0;
        if (m_left == 0) m_busy = 0;
      end else if (tmo_limit != 0) begin
        m_stall++;
        if (m_stall >= int'(tmo_limit)) begin
          m_busy = 0;
          abort = 1;
        end
      end
    end else if (enable && req != '0) begin
      m_src = rr_next();
      m_sel = m_src;
      m_last = m_src;
      m_busy = 1;
      m_left = (burst_len == 0) ? 1 : int'(burst_len);
      m_stall = 0;
      win_q.push_back(m_src);
      win_cyc.push_back(cyc);
    end
    if (err_clr) begin
      m_err = 0;
      m_esel = 0;
    end else if (abort && !m_err) begin
      m_err = 1;
      m_esel = m_src;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = $urandom;
    #1;
    check_all();
    model_step();
    @(posedge clk_hs);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_hs = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_data", 64'(out_data), 64'(0));
    repeat (2) @(posedge clk_hs);
    #1;
    rst_hs = 1'b1;
  endtask

  task automatic run_idle(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < max);
    if (n >= max) chk("wait_bound", 64'(busy), 64'(0));
  endtask

  int n;

  initial begin
    model_reset();
    @(posedge clk_hs);
    #1;
    do_reset();

    // first grant after reset goes to source 0, then reset mid-burst
    req = '1; enable = 1; burst_len = 3; out_ready = 1; src_valid = '1;
    tick();
    chk("first_grant", 64'(grant), 64'(1));
    tick();
    chk("mid_busy", 64'(busy), 64'(1));
    do_reset();

    // round robin over 0b1011 with 2-word bursts
    req = N'(4'b1011); burst_len = 2;
    win_q.delete(); win_cyc.delete(); dut_lasts = 0;
    n = 0;
    while (win_q.size() < 4 && n < 40) begin tick(); n++; end
    enable = 0;
    run_idle(20, n);
    chk("rr_cnt", 64'(win_q.size()), 64'(4));
    if (win_q.size() == 4) begin
      chk("rr_0", 64'(win_q[0]), 64'(0));
      chk("rr_1", 64'(win_q[1]), 64'(1));
      chk("rr_2", 64'(win_q[2]), 64'(3));
      chk("rr_3", 64'(win_q[3]), 64'(0));
      for (int i = 1; i < 4; i++)
        chk("rr_gap", 64'(win_cyc[i] - win_cyc[i-1]), 64'(3));
    end
    chk("rr_lasts", 64'(dut_lasts), 64'(4));

    // backpressure: 4-word burst with toggling out_ready
    req = N'(1) << 5; burst_len = 4; enable = 1; out_ready = 1;
    tick();
    enable = 0; dut_xfers = 0;
    n = 0;
    do begin
      out_ready = ~out_ready;
      tick();
      n++;
    end while (busy && n < 40);
    chk("bp_xfers", 64'(dut_xfers), 64'(4));
    out_ready = 1;

    // timeout on a source that never presents data
    req = N'(1) << 2; tmo_limit = 5; src_valid = '0; enable = 1;
    tick();
    chk("tmo_grant", 64'(grant), 64'(N'(1) << 2));
    enable = 0;
    run_idle(20, n);
    chk("tmo_cycles", 64'(n), 64'(5));
    chk("tmo_err_set", 64'(tmo_err), 64'(1));
    chk("tmo_sel_set", 64'(tmo_sel), 64'(2));
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("tmo_err_clr", 64'(tmo_err), 64'(0));
    chk("tmo_sel_clr", 64'(tmo_sel), 64'(0));

    // zero length means one word; length is sampled only at grant
    src_valid = '1; req = N'(1) << 7; burst_len = 0; enable = 1;
    tick();
    enable = 0; dut_xfers = 0;
    run_idle(20, n);
    chk("len0_xfers", 64'(dut_xfers), 64'(1));
    burst_len = 3; enable = 1;
    tick();
    burst_len = 9; enable = 0; dut_xfers = 0;
    run_idle(30, n);
    chk("len_keep", 64'(dut_xfers), 64'(3));

    // enable dropped mid-burst: burst finishes, no further grant
    req = N'(1) << 9; burst_len = 3; enable = 1;
    tick();
    enable = 0; dut_xfers = 0;
    run_idle(20, n);
    chk("en_xfers", 64'(dut_xfers), 64'(3));
    repeat (5) tick();
    chk("no_regrant", 64'(grant), 64'(0));
    enable = 1;
    tick();
    chk("reen_grant", 64'(grant), 64'(N'(1) << 9));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = N'({$urandom, $urandom} & {$urandom, $urandom});
      enable    = ($urandom_range(9) != 0);
      if ($urandom_range(5) == 0) burst_len = BW'($urandom_range(5));
      if ($urandom_range(30) == 0) tmo_limit = TW'($urandom_range(2) * 3);
      src_valid = N'({$urandom, $urandom} | {$urandom, $urandom});
      out_ready = ($urandom_range(3) != 0);
      err_clr   = ($urandom_range(40) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
